// File: rtl/wide_compare_sequencer.sv
// Wide A/B magnitude compare, one NrOfBits word per cycle, MS word first, early exit on first unequal word.
// Done pulses k+1 cycles after Start for k words examined; Start is ignored while Busy=1.
module wide_compare_sequencer #(
  parameter int NrOfBits  = 8,
  parameter int NrOfWords = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Start,
  input  logic                          Signed,
  input  logic [NrOfBits*NrOfWords-1:0] DataA,
  input  logic [NrOfBits*NrOfWords-1:0] DataB,
  output logic                          Busy,
  output logic                          Done,
  output logic                          A_EQ_B,
  output logic                          A_GT_B,
  output logic                          A_LT_B
);

  localparam int IW = (NrOfWords > 1) ? $clog2(NrOfWords) : 1;
  localparam logic [IW-1:0] LAST = IW'(NrOfWords - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                                state_q, state_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [NrOfWords-1:0][NrOfBits-1:0]    a_q, a_d, b_q, b_d;
  logic                                  sgn_q, sgn_d;
  logic                                  done_q, done_d;
  logic                                  eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic [NrOfBits-1:0] flip, cmp_a, cmp_b;
  logic                slice_gt, slice_lt;

  // Two's-complement compare on the top word is an unsigned compare with the sign bits inverted.
  always_comb begin
    flip               = '0;
    flip[NrOfBits-1]   = sgn_q && (idx_q == LAST);
    cmp_a              = a_q[idx_q] ^ flip;
    cmp_b              = b_q[idx_q] ^ flip;
    slice_gt           = cmp_a > cmp_b;
    slice_lt           = cmp_a < cmp_b;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = DataA;
          b_d     = DataB;
          sgn_d   = Signed;
          idx_d   = LAST;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slice_gt || slice_lt) begin
          eq_d    = 1'b0;
          gt_d    = slice_gt;
          lt_d    = slice_lt;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= LAST;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign Busy   = (state_q == RUN);
  assign Done   = done_q;
  assign A_EQ_B = eq_q;
  assign A_GT_B = gt_q;
  assign A_LT_B = lt_q;

endmodule
